ntt_stage_agu: RTL and testbench

Address and twiddle generator for one radix-2 Cooley-Tukey NTT stage. On a start pulse it walks every butterfly of the selected stage, one per cycle, and emits the coefficient-memory address pair plus the twiddle factor. These three values feed the `radix_2_ntt_pe` butterfly as `a`, `b` and `tf`. A valid/ready handshake lets memory read latency or a stalled write-back pause the sequence.

---
 rtl/ntt_pkg.sv | 10 +
 rtl/ntt_modmul.sv | 16 +
 rtl/ntt_stage_agu.sv | 117 +++++++++++
 tb/tb_ntt_stage_agu.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared constants and types for the NTT address/twiddle path.
package ntt_pkg;
  localparam int N_DEF      = 17;
  localparam int Q_DEF      = 65537;
  localparam int LOGL_DEF   = 5;
  localparam int OMEGA_DEF  = 2;
  localparam int NPAIRS_DEF = (1 << LOGL_DEF) / 2;

  typedef enum logic [1:0] {ST_IDLE, ST_PREP, ST_RUN, ST_DONE} agu_state_t;
endpackage

// File: rtl/ntt_modmul.sv
// Combinational canonical modular multiply: p = (x*y) mod Q.
module ntt_modmul import ntt_pkg::*; #(
  parameter int N = N_DEF,
  parameter int Q = Q_DEF
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] p
);
  localparam logic [2*N-1:0] QW = (2*N)'(Q);

  logic [2*N-1:0] prod;

  assign prod = {{N{1'b0}}, x} * {{N{1'b0}}, y};
  assign p    = N'(prod % QW);
endmodule

// File: rtl/ntt_stage_agu.sv
// Walks every butterfly of one radix-2 NTT stage, emitting (a, b, tf) per handshake.
module ntt_stage_agu import ntt_pkg::*; #(
  parameter int N     = N_DEF,
  parameter int Q     = Q_DEF,
  parameter int LOGL  = LOGL_DEF,
  parameter int OMEGA = OMEGA_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [LOGL-1:0] stage,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [LOGL-1:0] addr_a,
  output logic [LOGL-1:0] addr_b,
  output logic [N-1:0]    tf,
  output logic            out_last,
  output logic            done
);
  localparam int L = 1 << LOGL;

  agu_state_t      state;
  logic [LOGL-1:0] s_q, cnt, g, j;
  logic [N-1:0]    w;

  // half/2*half/last group base carry one extra bit so 2*half = L is representable
  logic [LOGL:0]   half, two_half, last_g;
  logic            hs, wrap, last_n;
  logic [LOGL-1:0] j_n, g_n;
  logic [N-1:0]    mm_x, mm_p;

  assign half     = (LOGL+1)'(1) << s_q;
  assign two_half = half << 1;
  assign last_g   = (LOGL+1)'(L) - two_half;
  assign hs       = out_valid & out_ready;
  assign wrap     = ({1'b0, j} == half - (LOGL+1)'(1));

  always_comb begin
    j_n    = wrap ? '0 : j + LOGL'(1);
    g_n    = wrap ? LOGL'({1'b0, g} + two_half) : g;
    last_n = ({1'b0, g_n} == last_g) && ({1'b0, j_n} == half - (LOGL+1)'(1));
  end

  // one multiplier: squares w during PREP, advances tf during RUN
  assign mm_x = (state == ST_PREP) ? w : tf;

  ntt_modmul #(.N(N), .Q(Q)) u_mul (.x(mm_x), .y(w), .p(mm_p));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      s_q       <= '0;
      cnt       <= '0;
      g         <= '0;
      j         <= '0;
      w         <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      addr_a    <= '0;
      addr_b    <= '0;
      tf        <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && (32'(stage) < LOGL)) begin
            s_q   <= stage;
            w     <= N'(OMEGA);
            cnt   <= LOGL'(LOGL - 1) - stage;
            busy  <= 1'b1;
            state <= ST_PREP;
          end
        end
        ST_PREP: begin
          if (cnt != '0) begin
            w   <= mm_p;
            cnt <= cnt - LOGL'(1);
          end else begin
            g         <= '0;
            j         <= '0;
            tf        <= N'(1);
            addr_a    <= '0;
            addr_b    <= LOGL'(half);
            out_last  <= (last_g == '0) && (half == (LOGL+1)'(1));
            out_valid <= 1'b1;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (hs) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              state     <= ST_DONE;
            end else begin
              g        <= g_n;
              j        <= j_n;
              tf       <= wrap ? N'(1) : mm_p;
              addr_a   <= g_n + j_n;
              addr_b   <= g_n + j_n + LOGL'(half);
              out_last <= last_n;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ntt_stage_agu.sv
// Directed + randomized-backpressure bench against a pair-list reference model.
module tb_ntt_stage_agu;
  import ntt_pkg::*;

  localparam int N = N_DEF, Q = Q_DEF, LOGL = LOGL_DEF, OMEGA = OMEGA_DEF;
  localparam int L = 1 << LOGL;

  logic            clk, rst_n, start, out_ready;
  logic [LOGL-1:0] stage;
  logic            busy, out_valid, out_last, done;
  logic [LOGL-1:0] addr_a, addr_b;
  logic [N-1:0]    tf;

  int tests = 0;
  int fails = 0;

  ntt_stage_agu dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stage(stage), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .addr_a(addr_a), .addr_b(addr_b),
    .tf(tf), .out_last(out_last), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint modpow(input longint b, input longint e);
    longint r = 1;
    for (longint k = 0; k < e; k++) r = (r * b) % Q;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 always ready, 1 random ready, 2 three-cycle stall at pair 5
  // abort_at >= 0 pulls reset while that pair is on the outputs
  task automatic run_stage(input int s, input int mode, input bit poke_start, input int abort_at);
    int ea[$], eb[$], et[$];
    int half, n, idx, cyc, hold;
    longint ws;
    bit rdy;
    half = 1 << s;
    ws   = modpow(OMEGA, longint'(1) << (LOGL - 1 - s));
    for (int gb = 0; gb < L; gb += 2 * half)
      for (int jj = 0; jj < half; jj++) begin
        ea.push_back(gb + jj);
        eb.push_back(gb + jj + half);
        et.push_back(int'(modpow(ws, jj)));
      end
    n = ea.size();
    chk($sformatf("s%0d_npairs", s), n, NPAIRS_DEF);

    start = 1'b1; stage = LOGL'(s); out_ready = 1'b0;
    step();
    start = 1'b0;
    chk($sformatf("s%0d_busy_after_start", s), busy, 1);
    for (int k = 0; k < LOGL - s; k++) begin
      chk($sformatf("s%0d_prep_valid_%0d", s, k), out_valid, 0);
      step();
    end

    idx = 0; cyc = 0; hold = 0;
    while (idx < n && cyc < 400) begin
      case (mode)
        1:       rdy = ($urandom_range(3) != 0);
        2:       rdy = !(idx == 5 && hold < 3);
        default: rdy = 1'b1;
      endcase
      if (!rdy) hold++;
      out_ready = rdy;
      if (poke_start && idx == 3) begin start = 1'b1; stage = '0; end
      chk($sformatf("s%0d_valid_%0d", s, idx), out_valid, 1);
      chk($sformatf("s%0d_a_%0d", s, idx), addr_a, ea[idx]);
      chk($sformatf("s%0d_b_%0d", s, idx), addr_b, eb[idx]);
      chk($sformatf("s%0d_tf_%0d", s, idx), tf, et[idx]);
      chk($sformatf("s%0d_last_%0d", s, idx), out_last, idx == n - 1);
      chk($sformatf("s%0d_done_low_%0d", s, idx), done, 0);
      if (idx == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_a", addr_a, 0);
        chk("abort_b", addr_b, 0);
        chk("abort_tf", tf, 0);
        chk("abort_busy", busy, 0);
        chk("abort_last", out_last, 0);
        step();
        chk("abort_done", done, 0);
        rst_n = 1'b1;
        out_ready = 1'b0;
        step();
        chk("abort_idle_valid", out_valid, 0);
        return;
      end
      step();
      start = 1'b0;
      if (rdy) idx++;
      cyc++;
    end
    chk($sformatf("s%0d_all_pairs", s), idx, n);
    out_ready = 1'b0;
    chk($sformatf("s%0d_done", s), done, 1);
    chk($sformatf("s%0d_valid_off", s), out_valid, 0);
    chk($sformatf("s%0d_busy_in_done", s), busy, 1);
    step();
    chk($sformatf("s%0d_done_pulse", s), done, 0);
    chk($sformatf("s%0d_busy_off", s), busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stage = '0; out_ready = 1'b0;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_last", out_last, 0);
    chk("rst_a", addr_a, 0);
    chk("rst_b", addr_b, 0);
    chk("rst_tf", tf, 0);
    rst_n = 1'b1;
    step();

    run_stage(0, 0, 1'b0, -1);
    run_stage(4, 0, 1'b0, -1);
    run_stage(2, 0, 1'b0, -1);
    run_stage(4, 2, 1'b0, -1);
    run_stage(4, 1, 1'b1, -1);

    start = 1'b1; stage = LOGL'(5);
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("bad_stage_busy_%0d", k), busy, 0);
      chk($sformatf("bad_stage_valid_%0d", k), out_valid, 0);
      chk($sformatf("bad_stage_done_%0d", k), done, 0);
      step();
    end

    run_stage(3, 1, 1'b0, -1);
    run_stage(2, 0, 1'b0, 7);
    run_stage(2, 0, 1'b0, -1);
    run_stage(1, 1, 1'b0, -1);
    run_stage(0, 1, 1'b1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
